// File: rtl/uart_pkg.sv
// Shared UART scheduler definitions.
// State encodings, frame constants and arbitration helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int BIT_WIDTH_DEF = 8;
  localparam int FRAME_OVH     = 2;

  // Distance of slot i from the slot just after last, modulo n.
  function automatic int rr_dist(input int i, input int last, input int n);
    return (i + n - 1 - last) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter_r0.sv
// Combinational round-robin picker.
// Searches upward from last+1, wrapping modulo N.
module rr_arbiter_r0
  import uart_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  int best;

  // Nearest eligible slot after last wins; distances are distinct.
  always_comb begin
    grant = '0;
    idx   = '0;
    best  = N;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && rr_dist(i, int'(last), N) < best)
        best = rr_dist(i, int'(last), N);
    end
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && rr_dist(i, int'(last), N) == best) begin
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb_r0.sv
// Round-robin scheduler sharing one UART transmitter.
// Grants a requester, strobes tx, tracks busy with a timeout.
module uart_tx_arb_r0
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int BUSY_TIMEOUT = 4,
  parameter int ID_W         = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_mask,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         uart_tx,
  output logic [BIT_WIDTH-1:0]         uart_data,
  input  logic                         uart_busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         active,
  output logic                         err_timeout,
  input  logic                         err_clr
);

  localparam logic [3:0] TO_LAST = 4'(BUSY_TIMEOUT - 1);

  state_t             state;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic [3:0]         tcnt;

  assign elig = req_valid & req_mask;

  rr_arbiter_r0 #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .eligible (elig),
    .last     (grant_id),
    .grant    (grant),
    .idx      (win)
  );

  // Accept pulse only in IDLE and never while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign active    = (state != IDLE);

  // Scheduler FSM with data latch, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      uart_tx     <= 1'b0;
      uart_data   <= '0;
      grant_id    <= ID_W'(NUM_REQ - 1);
      err_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      uart_tx <= 1'b0;
      if (err_clr)
        err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            uart_data <= req_data[int'(win)*BIT_WIDTH +: BIT_WIDTH];
            grant_id  <= win;
            uart_tx   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_busy) begin
            state <= WAIT_DONE;
          end else begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == TO_LAST) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!uart_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb_r0.sv
// Directed bench for uart_tx_arb_r0 with a transmitter busy model.
// Expected grants are queued when stimulus is driven.
module tb_uart_tx_arb_r0;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int TO = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*BW-1:0] req_data = '0;
  logic [N-1:0]    req_mask = '1;
  logic [N-1:0]    req_ready;
  logic            uart_tx;
  logic [BW-1:0]   uart_data;
  logic            uart_busy;
  logic [IW-1:0]   grant_id;
  logic            active;
  logic            err_timeout;
  logic            err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } sb_t;

  sb_t sb[$];

  logic model_en = 1'b1;
  int   bcnt;

  uart_tx_arb_r0 #(
    .NUM_REQ      (N),
    .BIT_WIDTH    (BW),
    .BUSY_TIMEOUT (TO),
    .ID_W         (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .req_ready   (req_ready),
    .uart_tx     (uart_tx),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises the cycle after tx, lasts BW+2 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bcnt <= 0;
    else if (bcnt != 0)
      bcnt <= bcnt - 1;
    else if (uart_tx && model_en)
      bcnt <= BW + 2;
  end

  assign uart_busy = (bcnt != 0);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    req_data[i*BW +: BW] = v;
  endtask

  task automatic push(input int id, input logic [7:0] d);
    sb_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    err_clr   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Wait for an accept, check it against the queue, then time the frame.
  task automatic expect_grant(input int pitch, input logic [N-1:0] clr);
    sb_t e;
    int  n;
    bit  got;
    got = 1'b0;
    #1;
    for (int w = 0; w < 60; w++) begin
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("accept_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("ready_onehot", 32'(req_ready), 32'd1 << e.id);
    step();
    chk("tx_strobe", 32'(uart_tx), 32'd1);
    chk("uart_data", 32'(uart_data), 32'(e.data));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("ready_issue", 32'(req_ready), 32'd0);
    req_valid = req_valid & ~clr;
    n = 1;
    while (active && n < 40) begin
      step();
      n++;
      if (active)
        chk("ready_busy", 32'(req_ready), 32'd0);
    end
    chk("pitch", 32'(n), 32'(pitch));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_tx", 32'(uart_tx), 32'd0);
    chk("rst_data", 32'(uart_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd3);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester 1
    set_lane(1, 8'hA5);
    req_mask  = 4'b1111;
    req_valid = 4'b0010;
    push(1, 8'hA5);
    expect_grant(13, 4'b0010);

    // All four continuously valid
    do_reset();
    set_lane(0, 8'h10);
    set_lane(1, 8'h21);
    set_lane(2, 8'h32);
    set_lane(3, 8'h43);
    req_valid = 4'b1111;
    push(0, 8'h10);
    push(1, 8'h21);
    push(2, 8'h32);
    push(3, 8'h43);
    push(0, 8'h10);
    for (int k = 0; k < 4; k++)
      expect_grant(13, 4'b0000);
    expect_grant(13, 4'b1111);

    // Mask 0101
    do_reset();
    req_mask  = 4'b0101;
    req_valid = 4'b1111;
    push(0, 8'h10);
    push(2, 8'h32);
    push(0, 8'h10);
    push(2, 8'h32);
    for (int k = 0; k < 3; k++)
      expect_grant(13, 4'b0000);
    expect_grant(13, 4'b1111);
    req_mask = 4'b1111;

    // Busy timeout, clear, and clear colliding with a set
    do_reset();
    model_en = 1'b0;
    set_lane(0, 8'h5A);
    req_valid = 4'b0001;
    push(0, 8'h5A);
    expect_grant(6, 4'b0001);
    chk("to_err_set", 32'(err_timeout), 32'd1);
    chk("to_idle", 32'(active), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err_timeout), 32'd0);
    set_lane(1, 8'h3C);
    req_valid = 4'b0010;
    #1;
    chk("to2_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    step();
    step();
    step();
    step();
    err_clr = 1'b1;
    chk("to2_active", 32'(active), 32'd1);
    chk("to2_err_pre", 32'(err_timeout), 32'd0);
    step();
    err_clr = 1'b0;
    chk("to2_set_wins", 32'(err_timeout), 32'd1);
    chk("to2_idle", 32'(active), 32'd0);
    step();
    chk("to2_sticky", 32'(err_timeout), 32'd1);
    model_en = 1'b1;

    // Reset mid-frame
    do_reset();
    set_lane(0, 8'h77);
    set_lane(2, 8'h99);
    req_valid = 4'b0001;
    #1;
    chk("mr_ready", 32'(req_ready), 32'b0001);
    step();
    chk("mr_tx", 32'(uart_tx), 32'd1);
    step();
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_tx0", 32'(uart_tx), 32'd0);
    chk("mr_active0", 32'(active), 32'd0);
    chk("mr_err0", 32'(err_timeout), 32'd0);
    chk("mr_data0", 32'(uart_data), 32'd0);
    chk("mr_ready0", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    req_valid = 4'b0101;
    push(0, 8'h77);
    expect_grant(13, 4'b0101);

    // Requester 3 withdraws while not in IDLE
    do_reset();
    set_lane(0, 8'h10);
    set_lane(2, 8'h42);
    set_lane(3, 8'h43);
    req_valid = 4'b0100;
    #1;
    chk("dr_ready", 32'(req_ready), 32'b0100);
    step();
    chk("dr_tx", 32'(uart_tx), 32'd1);
    chk("dr_gid", 32'(grant_id), 32'd2);
    req_valid = 4'b1001;
    step();
    step();
    step();
    step();
    chk("dr_active", 32'(active), 32'd1);
    chk("dr_no_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0001;
    push(0, 8'h10);
    expect_grant(13, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb_r0.md
# uart_tx_arb_r0

Round-robin scheduler that shares one `uart_tx_r0` transmitter among `NUM_REQ` byte sources. Each requester presents a byte with a valid/ready handshake. The block grants one requester at a time, latches its byte, pulses the transmitter's `tx` strobe, and tracks the transmitter's `busy` until the frame is done. It sits between the on-chip byte producers and the UART TX shift register, and reports a sticky error if the transmitter never acknowledges a strobe.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `BIT_WIDTH`, 8: data bits per frame; must match the transmitter's `BIT_WIDTH`.
- `BUSY_TIMEOUT`, 4: cycles allowed in WAIT_BUSY before the frame is dropped; 2..15.
- `ID_W`, 2: width of `grant_id`, equal to ceil(log2(`NUM_REQ`)), minimum 1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i has a byte; must be held with its data until `req_ready[i]`.
- `req_data`  in  `NUM_REQ*BIT_WIDTH`  byte of requester i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_mask`  in  `NUM_REQ`  1 = requester eligible; a masked requester is never granted.
- `req_ready`  out  `NUM_REQ`  one-hot, one-cycle accept pulse; the transfer occurs on the edge where valid and ready are both high.
- `uart_tx`  out  1  start strobe to the transmitter's `tx`.
- `uart_data`  out  `BIT_WIDTH`  registered byte to the transmitter's `dataIn`.
- `uart_busy`  in  1  the transmitter's `busy`.
- `grant_id`  out  `ID_W`  index of the last granted requester.
- `active`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  sticky; set when a WAIT_BUSY timeout occurs.
- `err_clr`  in  1  clears `err_timeout`; a set in the same cycle wins.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE:** eligible = `req_valid & req_mask`.
  - If eligible is nonzero, pick the winner by round-robin, searching from `grant_id`+1 upward and wrapping modulo `NUM_REQ`.
  - Assert `req_ready[winner]` combinationally in this cycle.
  - On the edge: latch `uart_data` from the winner's byte, set `grant_id` to the winner, go to ISSUE.
- **ISSUE:** `uart_tx`=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `uart_busy`=1, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When the counter reaches `BUSY_TIMEOUT`, set `err_timeout` and go to IDLE; the frame is dropped and not retried.
- **WAIT_DONE:** stay while `uart_busy`=1; on `uart_busy`=0 go to IDLE.
- Output decode:
  - `uart_tx` is high in ISSUE only.
  - `active` = (state != IDLE).
  - `req_ready` is all-zero outside IDLE.
- Requests, mask changes and data changes are ignored while not in IDLE.
- Dropping `req_valid` before ready is legal; no grant is made to that requester.
- `uart_data` holds its last value between frames.

## Timing
- Reset, asynchronous and immediate: state=IDLE, `uart_tx`=0, `uart_data`=0, `grant_id`=`NUM_REQ`-1 so requester 0 wins first, `err_timeout`=0, timeout counter=0, `req_ready`=0.
- The transmitter registers `tx` and raises `busy` the next cycle. `busy` then stays high for `BIT_WIDTH`+2 cycles and falls one cycle before the transmitter returns to idle.
- Accept at cycle T:
  - `uart_tx` high at T+1.
  - `busy` high from T+2 to T+`BIT_WIDTH`+3.
  - `busy` low at T+`BIT_WIDTH`+4.
  - IDLE at T+`BIT_WIDTH`+5, which is the earliest next accept.
- Back-to-back frame pitch is `BIT_WIDTH`+5 cycles, i.e. 13 for `BIT_WIDTH`=8.
- Never assert `uart_tx` in the cycle `busy` falls; the transmitter drops a strobe in that cycle. Returning to IDLE first guarantees this.
- `rst_n` asserted mid-frame: the scheduler returns to IDLE immediately and the in-flight byte is lost. The transmitter is reset by the same source.

## Structure
- Shared `uart_pkg` holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3;
  - default `BIT_WIDTH`;
  - frame overhead constant 2 (start and stop bits).
- Sub-module `rr_arbiter_r0`: combinational round-robin picker. Inputs are the eligible vector and the last-grant pointer; outputs are a one-hot grant and a binary index. It is reused by future bus schedulers.
- The top level holds the FSM, the data register, the timeout counter and the error flag.

## Test plan
- Requester 1 only, valid with data 0xA5, mask 4'b1111 -> `req_ready`=4'b0010 for one cycle, `uart_tx` one cycle later, `uart_data`=0xA5, `grant_id`=1; `active` drops 13 cycles after accept.
- All four valid continuously, data 0x10/0x21/0x32/0x43 -> grants in order 0,1,2,3,0, one grant every 13 cycles; the transmitter's serial output matches each byte.
- All valid, mask 4'b0101 -> grants alternate 0,2,0,2; requesters 1 and 3 never see ready.
- `uart_busy` tied to 0, `BUSY_TIMEOUT`=4, one request -> `err_timeout` set on the 4th cycle in WAIT_BUSY, back to IDLE. Pulse `err_clr` -> flag clears. `err_clr` in the same cycle as a new timeout -> flag stays set.
- `rst_n` low 5 cycles into a frame -> `uart_tx`, `active`, `err_timeout` and `uart_data` all 0 immediately. After release, requester 0 wins first despite requester 2 also being valid.
- Requester 3 drops valid during WAIT_DONE, requester 0 stays valid -> next grant is requester 0; no ready pulse is issued while not in IDLE.
